seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_W, default 4, SHALL set the pattern length in bits (legal range 2..32).
REQ-002 Parameter PAT_INIT, default 4'b0101 (PAT_W bits), SHALL be the pattern value loaded at reset.
REQ-003 Parameter CNT_W, default 8, SHALL set the match-counter width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-006 x  input  1  SHALL be the serial data bit.
REQ-007 x_valid  input  1  SHALL qualify x; x SHALL be ignored when x_valid=0.
REQ-008 overlap  input  1  SHALL select overlapping (1) or non-overlapping (0) detection.
REQ-009 pattern  input  PAT_W  SHALL be the new pattern; oldest bit in MSB.
REQ-010 pattern_load  input  1  SHALL latch pattern into the internal pattern register.
REQ-011 clear  input  1  SHALL synchronously clear the history, fill count, z and match_count.
REQ-012 z  output  1  SHALL be the registered match pulse.
REQ-013 match_count  output  CNT_W  SHALL be the registered count of matches.

Function
REQ-014 Block SHALL hold hist (PAT_W bits), fill (0..PAT_W) and pat_reg (PAT_W bits).
REQ-015 On an edge with x_valid=1: hist <= {hist[PAT_W-2:0], x}; fill increments, saturating at PAT_W.
REQ-016 A match SHALL occur on an edge where x_valid=1, updated fill = PAT_W and updated hist = pat_reg.
REQ-017 z SHALL be 1 for exactly the one cycle following a matching edge and 0 otherwise; latency is 1 edge from accepting the final bit.
REQ-018 overlap=1: after a match fill SHALL stay PAT_W, so consecutive matches may share bits (pattern 0101, stream 010101 -> 2 matches).
REQ-019 overlap=0: on a match fill SHALL be set to 0, so the next match needs PAT_W fresh valid bits.
REQ-020 overlap is sampled per edge; changing it mid-stream SHALL only affect the fill update of the current edge.
REQ-021 x_valid=0 edges SHALL hold hist, fill and match_count, and SHALL drive z to 0.
REQ-022 match_count SHALL increment by 1 per match and saturate at 2^CNT_W-1 (no wrap).
REQ-023 pattern_load=1: pat_reg <= pattern; hist and fill SHALL clear to 0; z SHALL be 0; x on that edge is discarded.
REQ-024 clear=1: hist, fill, z and match_count SHALL clear to 0; x on that edge is discarded; pat_reg is unchanged.
REQ-025 clear and pattern_load together SHALL apply both effects.
REQ-026 Priority SHALL be clear/pattern_load over x_valid.

Reset
REQ-027 While reset=0 (asynchronous, independent of clk): hist=0, fill=0, z=0, match_count=0, pat_reg=PAT_INIT.
REQ-028 Reset asserted mid-pattern SHALL discard partial history; detection restarts from fill=0 after release.
REQ-029 The first edge after reset deassertion SHALL be processed normally.

Configuration
REQ-030 Macro SEQDET_COUNT_EN defined: match_count SHALL be implemented per REQ-022.
REQ-031 SEQDET_COUNT_EN undefined: match_count SHALL be constant 0, with no counter flops; z behaviour SHALL be unchanged.

Verification
REQ-032 Defaults, overlap=1, valid stream 0,1,0,1,0,1 -> z pulses after bits 4 and 6; match_count=2.
REQ-033 Defaults, overlap=0, same stream -> single z pulse after bit 4; match_count=1; a further 0,1 gives a second match at bit 8.
REQ-034 Stream 0,1, then x_valid=0 for 3 cycles, then 0,1 -> one z pulse after the final bit; z=0 during the gap.
REQ-035 CNT_W=2, overlap=1, 6 back-to-back matches -> match_count reaches 3 and holds.
REQ-036 pattern_load of 4'b1101 after stream 1,1,0 -> no match from old bits; fresh 1,1,0,1 -> one z pulse.
REQ-037 reset pulsed low after bits 0,1,0, then 1 -> no match; z=0, match_count=0, pat_reg=PAT_INIT.

Source files
------------

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//   Serial pattern detector with a runtime-loadable pattern. Valid input bits
//   are shifted into a history register. A match is flagged when the history
//   holds PAT_W fresh bits equal to the pattern register. In overlapping mode,
//   consecutive matches may share bits. In non-overlapping mode, every match
//   needs PAT_W new bits.
//
//   Optional feature: define SEQDET_COUNT_EN to build the saturating match
//   counter. Without it, match_count is tied to 0 and no counter flops exist.
//
// Parameters
//   PAT_W        pattern length in bits (2..32)
//   PAT_INIT     pattern loaded at reset
//   CNT_W        match counter width
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous reset, active low
//   x            serial data bit
//   x_valid      qualifies x
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   pattern      new pattern; the oldest bit is in the MSB
//   pattern_load load pattern; also flushes history and fill
//   clear        clear history, fill, z and match_count
//   z            registered match pulse, one cycle after the final bit
//   match_count  registered saturating count of matches
// ---------------------------------------------------------------------------
module seq_detector_param #(
   parameter int                 PAT_W    = 4,
   parameter logic [PAT_W-1:0]   PAT_INIT = 4'b0101,
   parameter int                 CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             x_valid,
   input  logic             overlap,
   input  logic [PAT_W-1:0] pattern,
   input  logic             pattern_load,
   input  logic             clear,
   output logic             z,
   output logic [CNT_W-1:0] match_count
);

   localparam int               FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  hist_q;
   logic [PAT_W-1:0]  pat_q;
   logic [FILL_W-1:0] fill_q;
   logic              z_q;

   logic [PAT_W-1:0]  hist_upd;
   logic [FILL_W-1:0] fill_inc;
   logic              match;
   logic              flush;

   // A clear or a pattern load takes priority over the data path. The x
   // presented on that edge is discarded.
   assign flush = clear | pattern_load;

   always_comb begin
      hist_upd = {hist_q[PAT_W-2:0], x};
      fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
      match    = x_valid && !flush && (fill_inc == FILL_FULL) && (hist_upd == pat_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q <= '0;
         fill_q <= '0;
         z_q    <= 1'b0;
         pat_q  <= PAT_INIT;
      end else if (flush) begin
         hist_q <= '0;
         fill_q <= '0;
         z_q    <= 1'b0;
         if (pattern_load)
            pat_q <= pattern;
      end else if (x_valid) begin
         hist_q <= hist_upd;
         // In non-overlapping mode, restarting the fill forces PAT_W fresh
         // bits before the next match can occur.
         fill_q <= (match && !overlap) ? '0 : fill_inc;
         z_q    <= match;
      end else begin
         z_q    <= 1'b0;
      end
   end

   assign z = z_q;

`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   // The count clears only on clear or reset. A pattern load alone keeps it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else if (clear)
         cnt_q <= '0;
      else if (match && (cnt_q != '1))
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign match_count = cnt_q;
`else
   assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//   Directed-vector bench with a scoreboard. Each driven edge pushes its
//   hand-computed z / match_count expectation. A monitor on the falling edge
//   pops each expectation and compares it with the DUT. Expected counts become
//   0 when SEQDET_COUNT_EN is not defined. CNT_W is 2 so that the counter
//   saturates quickly.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

   localparam int CNT_W = 2;
`ifdef SEQDET_COUNT_EN
   localparam bit CEN = 1'b1;
`else
   localparam bit CEN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             x = 1'b0;
   logic             x_valid = 1'b0;
   logic             overlap = 1'b1;
   logic [3:0]       pattern = 4'b0000;
   logic             pattern_load = 1'b0;
   logic             clear = 1'b0;
   logic             z;
   logic [CNT_W-1:0] match_count;

   typedef struct {
      logic             z;
      logic [CNT_W-1:0] cnt;
      string            name;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   seq_detector_param #(
      .PAT_W    (4),
      .PAT_INIT (4'b0101),
      .CNT_W    (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .x            (x),
      .x_valid      (x_valid),
      .overlap      (overlap),
      .pattern      (pattern),
      .pattern_load (pattern_load),
      .clear        (clear),
      .z            (z),
      .match_count  (match_count)
   );

   function automatic logic [CNT_W-1:0] ec(input int n);
      return CEN ? CNT_W'(n) : '0;
   endfunction

   // Inputs change just after a falling edge. The expectation for the rising
   // edge is queued just after that edge, and the monitor checks it on the
   // next falling edge.
   task automatic drive(input logic rst, input logic v, input logic xb,
                        input logic ov, input logic ld, input logic clr,
                        input logic [3:0] pat, input logic ez, input int n,
                        input string nm);
      exp_t e;
      @(negedge clk);
      #1;
      reset = rst; x_valid = v; x = xb; overlap = ov;
      pattern_load = ld; clear = clr; pattern = pat;
      @(posedge clk);
      #1;
      e.z = ez; e.cnt = ec(n); e.name = nm;
      q.push_back(e);
   endtask

   task automatic bin(input logic xb, input logic ov, input logic ez,
                      input int n, input string nm);
      drive(1'b1, 1'b1, xb, ov, 1'b0, 1'b0, 4'b0000, ez, n, nm);
   endtask

   // An idle edge drives x=1 so that a leak of x into the history would show.
   task automatic idle(input int n, input string nm);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, n, nm);
   endtask

   task automatic clr(input string nm);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 0, nm);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         total++;
         if (z !== e.z || match_count !== e.cnt) begin
            bad++;
            $display("FAIL %s: got z=%0b cnt=%0d, expected z=%0b cnt=%0d",
                     e.name, z, match_count, e.z, e.cnt);
         end
      end
   end

   initial begin
      // Reset state while reset is held low
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 0, "rst_hold0");
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 0, "rst_hold1");

      // Overlapping mode, stream 0,1,0,1,0,1
      bin(0, 1, 0, 0, "ov_b1"); bin(1, 1, 0, 0, "ov_b2");
      bin(0, 1, 0, 0, "ov_b3"); bin(1, 1, 1, 1, "ov_b4");
      bin(0, 1, 0, 1, "ov_b5"); bin(1, 1, 1, 2, "ov_b6");
      clr("clr1");

      // Non-overlapping mode, same stream plus 0,1
      bin(0, 0, 0, 0, "no_b1"); bin(1, 0, 0, 0, "no_b2");
      bin(0, 0, 0, 0, "no_b3"); bin(1, 0, 1, 1, "no_b4");
      bin(0, 0, 0, 1, "no_b5"); bin(1, 0, 0, 1, "no_b6");
      bin(0, 0, 0, 1, "no_b7"); bin(1, 0, 1, 2, "no_b8");
      idle(2, "no_idle");
      clr("clr2");

      // Gap of three invalid cycles inside the pattern
      bin(0, 1, 0, 0, "gap_b1"); bin(1, 1, 0, 0, "gap_b2");
      idle(0, "gap_i1"); idle(0, "gap_i2"); idle(0, "gap_i3");
      bin(0, 1, 0, 0, "gap_b3"); bin(1, 1, 1, 1, "gap_b4");
      clr("clr3");

      // Six back-to-back overlapping matches; the 2-bit count holds at 3
      bin(0, 1, 0, 0, "sat_p1"); bin(1, 1, 0, 0, "sat_p2");
      bin(0, 1, 0, 0, "sat_p3"); bin(1, 1, 1, 1, "sat_m1");
      bin(0, 1, 0, 1, "sat_q2"); bin(1, 1, 1, 2, "sat_m2");
      bin(0, 1, 0, 2, "sat_q3"); bin(1, 1, 1, 3, "sat_m3");
      bin(0, 1, 0, 3, "sat_q4"); bin(1, 1, 1, 3, "sat_m4");
      bin(0, 1, 0, 3, "sat_q5"); bin(1, 1, 1, 3, "sat_m5");
      bin(0, 1, 0, 3, "sat_q6"); bin(1, 1, 1, 3, "sat_m6");
      clr("clr4");

      // Load 1101 after 1,1,0; the old bits must not complete a match
      bin(1, 1, 0, 0, "ld_o1"); bin(1, 1, 0, 0, "ld_o2"); bin(0, 1, 0, 0, "ld_o3");
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1101, 1'b0, 0, "ld_edge");
      bin(1, 1, 0, 0, "ld_f1"); bin(1, 1, 0, 0, "ld_f2");
      bin(0, 1, 0, 0, "ld_f3"); bin(1, 1, 1, 1, "ld_f4");

      // Reset mid-pattern restores PAT_INIT and discards the partial history
      bin(0, 1, 0, 1, "rs_b1"); bin(1, 1, 0, 1, "rs_b2"); bin(0, 1, 0, 1, "rs_b3");
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 0, "rs_low");
      bin(1, 1, 0, 0, "rs_b4");
      bin(0, 1, 0, 0, "rs_c1"); bin(1, 1, 0, 0, "rs_c2");
      bin(0, 1, 0, 0, "rs_c3"); bin(1, 1, 1, 1, "rs_init_match");

      // Clear and pattern load on the same edge
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0011, 1'b0, 0, "clr_ld");
      bin(0, 1, 0, 0, "cl_b1"); bin(0, 1, 0, 0, "cl_b2");
      bin(1, 1, 0, 0, "cl_b3"); bin(1, 1, 1, 1, "cl_b4");

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      #2;
      if (q.size() != 0) begin
         bad++;
         total++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
